// File: rtl/constmap_scheduler.sv
// Round-robin arbiter sharing one note-to-phase-increment constant ROM
// between NUM_REQ requesters, with a one-entry last-result cache.
module constmap_scheduler #(
  parameter int NUM_REQ = 8,
  parameter int ROM_LAT = 1,
  parameter int ID_W    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [9*NUM_REQ-1:0] note_in,
  input  logic                 cache_flush,
  output logic [NUM_REQ-1:0]   ack,
  output logic [23:0]          const_out,
  output logic                 const_valid,
  output logic [ID_W-1:0]      const_id,
  output logic [8:0]           rom_sound,
  input  logic [23:0]          rom_constant
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    DONE
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] gnt_next;
  logic            found;
  logic [8:0]      pick_raw;
  logic [8:0]      pick_note;
  logic [8:0]      note_r;
  logic [8:0]      cache_note;
  logic [23:0]     cache_const;
  logic            cache_valid;
  logic [1:0]      cnt;
  logic            hit;

  // Scan downward so the requester closest to rr_ptr is the one kept.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[ID_W'(idx)]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    pick_raw  = note_in[9*int'(pick) +: 9];
    pick_note = pick_raw[8] ? 9'd255 : pick_raw;
    hit       = cache_valid && (pick_note == cache_note);
    gnt_next  = (gnt_id == ID_W'(NUM_REQ - 1))
              ? '0 : gnt_id + ID_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt_id      <= '0;
      note_r      <= '0;
      cache_note  <= '0;
      cache_const <= '0;
      cache_valid <= 1'b0;
      cnt         <= '0;
      ack         <= '0;
      const_out   <= '0;
      const_valid <= 1'b0;
      const_id    <= '0;
      rom_sound   <= '0;
    end else begin
      ack         <= '0;
      const_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt_id <= pick;
            note_r <= pick_note;
            if (hit) begin
              const_out   <= cache_const;
              const_valid <= 1'b1;
              const_id    <= pick;
              ack         <= NUM_REQ'(1) << pick;
              state       <= DONE;
            end else begin
              // Present the address early so the ROM latency
              // starts counting from the ADDR cycle.
              rom_sound <= pick_note;
              state     <= ADDR;
            end
          end
        end
        ADDR: begin
          rom_sound <= note_r;
          cnt       <= 2'(ROM_LAT);
          state     <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            const_out   <= rom_constant;
            cache_note  <= note_r;
            cache_const <= rom_constant;
            cache_valid <= 1'b1;
            const_valid <= 1'b1;
            const_id    <= gnt_id;
            ack         <= NUM_REQ'(1) << gnt_id;
            state       <= DONE;
          end
        end
        DONE: begin
          rr_ptr <= gnt_next;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Flush beats a simultaneous cache fill.
      if (cache_flush) cache_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_constmap_scheduler.sv
// Randomized bench for constmap_scheduler against an arithmetic
// model of arbitration order, cache contents and latency.
module tb_constmap_scheduler;

  localparam int N   = 8;
  localparam int LAT = 1;
  localparam int IW  = 3;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_v;
  logic [9*N-1:0] note_in;
  logic           flush;
  logic [N-1:0]   ack;
  logic [23:0]    const_out;
  logic           const_valid;
  logic [IW-1:0]  const_id;
  logic [8:0]     rom_sound;
  logic [23:0]    rom_constant;

  int notes [N];
  int nassert = 0;
  int nfail   = 0;

  int          m_ptr;
  bit          m_cv;
  int          m_cn;
  logic [23:0] m_cc;
  int          m_snd;

  constmap_scheduler #(.NUM_REQ(N), .ROM_LAT(LAT), .ID_W(IW)) dut (
    .clk(clk),
    .reset(reset),
    .req(req_v),
    .note_in(note_in),
    .cache_flush(flush),
    .ack(ack),
    .const_out(const_out),
    .const_valid(const_valid),
    .const_id(const_id),
    .rom_sound(rom_sound),
    .rom_constant(rom_constant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    note_in = '0;
    for (int i = 0; i < N; i++) note_in[9*i +: 9] = 9'(notes[i]);
  end

  function automatic logic [23:0] rom_f(input logic [7:0] a);
    logic [7:0] b;
    b = a * 8'd3;
    if (a == 8'd69) return 24'h00D9A1;
    return {a ^ 8'h3C, b, ~a};
  endfunction

  // ROM with LAT register stages between address and data.
  logic [23:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= rom_f(rom_sound[7:0]);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rom_constant = pipe[LAT-1];

  task automatic chk(input string tag, input int got, input int exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_cv  = 0;
    m_cn  = 0;
    m_cc  = '0;
    m_snd = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req_v = '0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic flush_idle();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_cv = 0;
  endtask

  // Called at a negedge with the DUT idle and inputs applied.
  // fmode: 0 none, 1 flush in grant cycle, 2 flush on cache fill.
  task automatic serve(input bit drop, input int fmode);
    int id, cl, lat, k;
    bit hit, got;
    logic [23:0] ec;
    id = 0;
    for (int j = N - 1; j >= 0; j--) begin
      int c;
      c = (m_ptr + j) % N;
      if (req_v[c]) id = c;
    end
    cl  = notes[id] > 255 ? 255 : notes[id];
    hit = m_cv && (cl == m_cn);
    lat = hit ? 1 : LAT + 2;
    ec  = hit ? m_cc : rom_f(8'(cl));
    if (fmode == 1) flush = 1'b1;
    got = 0;
    for (k = 1; k <= lat + 4 && !got; k++) begin
      @(negedge clk);
      if (k == 1) flush = 1'b0;
      if (fmode == 2 && k == lat) flush = 1'b0;
      if (k == 1 && !hit) chk("rom_sound_addr", int'(rom_sound), cl);
      if (const_valid) begin
        got = 1;
        chk("latency", k, lat);
        chk("const_id", int'(const_id), id);
        chk("const_out", int'(const_out), int'(ec));
        chk("ack_onehot", int'(ack), 1 << id);
      end else begin
        chk("ack_quiet", int'(ack), 0);
      end
      if (fmode == 2 && !hit && k == lat - 1) flush = 1'b1;
    end
    flush = 1'b0;
    chk("valid_seen", int'(got), 1);
    chk("rom_sound_hold", int'(rom_sound), hit ? m_snd : cl);
    if (fmode == 1) m_cv = 0;
    if (!hit) begin
      m_cn  = cl;
      m_cc  = ec;
      m_cv  = (fmode != 2);
      m_snd = cl;
    end
    m_ptr = (id + 1) % N;
    if (drop) req_v[id] = 1'b0;
    else notes[id] = $urandom_range(0, 511);
    @(negedge clk);
    chk("valid_pulse", int'(const_valid), 0);
    chk("ack_pulse", int'(ack), 0);
  endtask

  initial begin
    reset = 1'b1;
    req_v = '0;
    flush = 1'b0;
    for (int i = 0; i < N; i++) notes[i] = 0;
    model_reset();
    apply_reset();
    chk("rst_ack", int'(ack), 0);
    chk("rst_valid", int'(const_valid), 0);
    chk("rst_out", int'(const_out), 0);
    chk("rst_id", int'(const_id), 0);
    chk("rst_sound", int'(rom_sound), 0);

    // Single miss: note 69 from requester 2.
    notes[2] = 69;
    req_v[2] = 1'b1;
    serve(1, 0);

    // All requesters, distinct notes, round-robin order.
    apply_reset();
    for (int i = 0; i < N; i++) notes[i] = 10 + 20 * i;
    req_v = '1;
    for (int i = 0; i < N + 1; i++) begin
      chk("rr_order", m_ptr, i % N);
      serve(0, 0);
    end
    req_v = '0;
    @(negedge clk);

    // Same note twice: second one is a cache hit.
    notes[5] = 40;
    req_v[5] = 1'b1;
    serve(1, 0);
    notes[1] = 40;
    req_v[1] = 1'b1;
    serve(1, 0);

    // Flush between the two requests forces a ROM read.
    flush_idle();
    notes[3] = 40;
    req_v[3] = 1'b1;
    serve(1, 0);
    chk("refilled", int'(m_cv), 1);

    // Out-of-range note clamps to 255.
    notes[6] = 300;
    req_v[6] = 1'b1;
    serve(1, 0);

    // Flush coinciding with the cache fill leaves cache empty.
    notes[0] = 123;
    req_v[0] = 1'b1;
    serve(1, 2);
    notes[4] = 123;
    req_v[4] = 1'b1;
    serve(1, 0);

    // Flush during a hit grant does not cancel the hit.
    notes[2] = 123;
    req_v[2] = 1'b1;
    serve(1, 1);

    // Reset while waiting on the ROM aborts the request.
    notes[7] = 77;
    req_v[7] = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    req_v = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      chk("abort_valid", int'(const_valid), 0);
      chk("abort_ack", int'(ack), 0);
      @(negedge clk);
    end
    notes[1] = 91;
    notes[7] = 92;
    req_v[1] = 1'b1;
    req_v[7] = 1'b1;
    serve(1, 0);
    serve(1, 0);

    // Random traffic with repeated notes, clamps and flushes.
    for (int t = 0; t < 60; t++) begin
      if (req_v == '0 && $urandom_range(0, 3) == 0) flush_idle();
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] && $urandom_range(0, 2) == 0) begin
          req_v[i] = 1'b1;
          notes[i] = ($urandom_range(0, 9) == 0)
                   ? 300 : 40 * $urandom_range(0, 7);
        end
      end
      if (req_v == '0) begin
        req_v[t % N] = 1'b1;
        notes[t % N] = 40;
      end
      serve(bit'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
